// File: rtl/decode_front_pkg.sv
// Shared decode-stage definitions: MIPS branch/jump opcodes and funct codes,
// pipeline bus widths and the fetch->decode payload layout.
package decode_front_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned IF_ID_W      = 65;
    localparam int unsigned ID_EXE_BUS_W = 66;
    localparam int unsigned JBR_BUS_W    = 33;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    // Fetch-to-decode payload, MSB first.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            fetch_error;
    } if_id_t;

endpackage

// File: rtl/decode_front_branch_unit.sv
// Combinational branch/jump decode: classifies the instruction, evaluates the
// branch condition and computes the redirect target.
// Ports: inst, pc, rs_value, rt_value in; is_jbr, taken, target out.
module branch_unit
    import decode_front_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs_value,
    input  logic [XLEN-1:0] rt_value,
    output logic            is_jbr,
    output logic            taken,
    output logic [XLEN-1:0] target
);

    logic [5:0]      opcode;
    logic [4:0]      rt_field;
    logic [5:0]      funct;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] j_target;
    logic            rs_zero;
    logic            rs_neg;

    assign opcode    = inst[31:26];
    assign rt_field  = inst[20:16];
    assign funct     = inst[5:0];
    assign pc_plus4  = pc + XLEN'(4);
    // Offset is word-scaled and sign-extended; the add wraps modulo 2^32.
    assign br_target = pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], inst[25:0], 2'b00};
    assign rs_zero   = (rs_value == '0);
    assign rs_neg    = rs_value[XLEN-1];

    // Classification, condition and target select.
    always_comb begin
        is_jbr = 1'b0;
        taken  = 1'b0;
        target = br_target;
        unique case (opcode)
            OP_BEQ: begin
                is_jbr = 1'b1;
                taken  = (rs_value == rt_value);
            end
            OP_BNE: begin
                is_jbr = 1'b1;
                taken  = (rs_value != rt_value);
            end
            OP_BLEZ: begin
                is_jbr = 1'b1;
                taken  = rs_neg || rs_zero;
            end
            OP_BGTZ: begin
                is_jbr = 1'b1;
                taken  = !rs_neg && !rs_zero;
            end
            OP_REGIMM: begin
                if (rt_field == RT_BLTZ) begin
                    is_jbr = 1'b1;
                    taken  = rs_neg;
                end else if (rt_field == RT_BGEZ) begin
                    is_jbr = 1'b1;
                    taken  = !rs_neg;
                end
            end
            OP_J, OP_JAL: begin
                is_jbr = 1'b1;
                taken  = 1'b1;
                target = j_target;
            end
            OP_SPECIAL: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    is_jbr = 1'b1;
                    taken  = 1'b1;
                    target = rs_value;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_front.sv
// Decode stage front end: holds one instruction from fetch, handshakes with
// fetch and execute, resolves branches/jumps and tracks the delay slot.
// Ports: clk/resetn (sync, active-low); IF_over, IF_ID_bus from fetch;
// exc_flush; EXE_allow_in; rs/rt values and hazard from the register file;
// rs_addr/rt_addr to the register file; ID_valid, ID_over, ID_allow_in,
// next_fetch handshakes; jbr_bus redirect to fetch; ID_EXE_bus to execute.
module decode_front
    import decode_front_pkg::*;
#(
    parameter int unsigned START_FLAG_W = 1,
    parameter int unsigned ID_EXE_W     = ID_EXE_BUS_W
)
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 IF_over,
    input  logic [IF_ID_W-1:0]   IF_ID_bus,
    input  logic                 exc_flush,
    input  logic                 EXE_allow_in,
    input  logic [XLEN-1:0]      rs_value,
    input  logic                 rs_hazard,
    input  logic [XLEN-1:0]      rt_value,
    output logic [4:0]           rs_addr,
    output logic [4:0]           rt_addr,
    output logic                 ID_valid,
    output logic                 ID_over,
    output logic                 ID_allow_in,
    output logic                 next_fetch,
    output logic [JBR_BUS_W-1:0] jbr_bus,
    output logic [ID_EXE_W-1:0]  ID_EXE_bus
);

    if_id_t                  fetch_in;
    if_id_t                  lat;
    logic                    id_valid_q;
    logic [START_FLAG_W-1:0] slot_pending;
    logic                    latch_en;
    logic                    depart;
    logic                    is_jbr;
    logic                    br_taken;
    logic [XLEN-1:0]         br_target;
    logic                    jbr_taken;
    logic                    jbr_real;

    assign fetch_in    = if_id_t'(IF_ID_bus);
    assign ID_valid    = id_valid_q;
    assign ID_over     = id_valid_q && !rs_hazard;
    assign ID_allow_in = !id_valid_q || (ID_over && EXE_allow_in);
    assign next_fetch  = exc_flush || (IF_over && ID_allow_in);
    assign latch_en    = IF_over && ID_allow_in && !exc_flush;
    assign depart      = ID_over && EXE_allow_in;

    assign rs_addr = lat.inst[25:21];
    assign rt_addr = lat.inst[20:16];

    branch_unit u_branch_unit (
        .inst     (lat.inst),
        .pc       (lat.pc),
        .rs_value (rs_value),
        .rt_value (rt_value),
        .is_jbr   (is_jbr),
        .taken    (br_taken),
        .target   (br_target)
    );

    // A faulted fetch is never a control transfer.
    assign jbr_real  = is_jbr && !lat.fetch_error;
    assign jbr_taken = id_valid_q && jbr_real && br_taken;
    assign jbr_bus   = {jbr_taken, br_target};

    assign ID_EXE_bus = ID_EXE_W'({lat.pc, lat.inst, lat.fetch_error, slot_pending});

    // Valid flag, latched instruction and delay-slot flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            id_valid_q   <= 1'b0;
            slot_pending <= '0;
            lat          <= '0;
        end else begin
            if (exc_flush) begin
                id_valid_q <= 1'b0;
            end else if (ID_allow_in) begin
                id_valid_q <= IF_over;
            end

            if (latch_en) begin
                lat <= fetch_in;
            end

            // Each departure rewrites the flag, so a branch in a delay slot re-arms it.
            if (exc_flush) begin
                slot_pending <= '0;
            end else if (depart) begin
                slot_pending <= START_FLAG_W'(jbr_real);
            end
        end
    end

endmodule

// File: tb/tb_decode_front.sv
// Directed bench for decode_front: vector table of single instructions plus
// hand-written reset, delay-slot, hazard and flush sequences.
module tb_decode_front;

    logic        clk;
    logic        resetn;
    logic        IF_over;
    logic [64:0] IF_ID_bus;
    logic        exc_flush;
    logic        EXE_allow_in;
    logic [31:0] rs_value;
    logic        rs_hazard;
    logic [31:0] rt_value;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        ID_valid;
    logic        ID_over;
    logic        ID_allow_in;
    logic        next_fetch;
    logic [32:0] jbr_bus;
    logic [65:0] ID_EXE_bus;

    int n_checks = 0;
    int n_fail   = 0;

    decode_front dut (
        .clk          (clk),
        .resetn       (resetn),
        .IF_over      (IF_over),
        .IF_ID_bus    (IF_ID_bus),
        .exc_flush    (exc_flush),
        .EXE_allow_in (EXE_allow_in),
        .rs_value     (rs_value),
        .rs_hazard    (rs_hazard),
        .rt_value     (rt_value),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .ID_valid     (ID_valid),
        .ID_over      (ID_over),
        .ID_allow_in  (ID_allow_in),
        .next_fetch   (next_fetch),
        .jbr_bus      (jbr_bus),
        .ID_EXE_bus   (ID_EXE_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fe;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic        exp_jbr;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge, leaving room before the inputs change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_idle();
        IF_over   = 1'b0;
        exc_flush = 1'b1;
        tick();
        exc_flush = 1'b0;
    endtask

    task automatic load(input logic [31:0] pc, input logic [31:0] inst, input logic fe);
        IF_over      = 1'b1;
        IF_ID_bus    = {pc, inst, fe};
        EXE_allow_in = 1'b0;
        tick();
        IF_over      = 1'b0;
        #1;
    endtask

    function automatic vec_t mkv(input string name, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic fe, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic tk, input logic [31:0] tgt, input logic jbr);
        vec_t v;
        v.name = name; v.pc = pc; v.inst = inst; v.fe = fe; v.rs = rs; v.rt = rt;
        v.exp_taken = tk; v.exp_target = tgt; v.exp_jbr = jbr;
        return v;
    endfunction

    initial begin
        logic [31:0] held;

        vecs[0]  = mkv("beq_taken",   32'hBFC00010, mk_i(6'h04, 5'd1, 5'd2, 16'h0003), 1'b0, 32'd5, 32'd5, 1'b1, 32'hBFC00020, 1'b1);
        vecs[1]  = mkv("bne_eq",      32'hBFC00200, mk_i(6'h05, 5'd1, 5'd2, 16'hFFFF), 1'b0, 32'd9, 32'd9, 1'b0, 32'h0, 1'b1);
        vecs[2]  = mkv("bne_ne_back", 32'h00001000, mk_i(6'h05, 5'd1, 5'd2, 16'hFFFF), 1'b0, 32'd1, 32'd2, 1'b1, 32'h00001000, 1'b1);
        vecs[3]  = mkv("blez_zero",   32'h00002000, mk_i(6'h06, 5'd7, 5'd0, 16'h0010), 1'b0, 32'd0, 32'd3, 1'b1, 32'h00002044, 1'b1);
        vecs[4]  = mkv("blez_pos",    32'h00002000, mk_i(6'h06, 5'd7, 5'd0, 16'h0010), 1'b0, 32'd1, 32'd0, 1'b0, 32'h0, 1'b1);
        vecs[5]  = mkv("bgtz_neg",    32'h00003000, mk_i(6'h07, 5'd8, 5'd0, 16'h0001), 1'b0, 32'h80000000, 32'd0, 1'b0, 32'h0, 1'b1);
        vecs[6]  = mkv("bgtz_pos",    32'h00003000, mk_i(6'h07, 5'd8, 5'd0, 16'h0001), 1'b0, 32'd7, 32'd0, 1'b1, 32'h00003008, 1'b1);
        vecs[7]  = mkv("bltz_neg",    32'h00004000, mk_i(6'h01, 5'd9, 5'd0, 16'h0002), 1'b0, 32'hFFFFFFFF, 32'd0, 1'b1, 32'h0000400C, 1'b1);
        vecs[8]  = mkv("bgez_zero",   32'h00005000, mk_i(6'h01, 5'd9, 5'd1, 16'h8000), 1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFE5004, 1'b1);
        vecs[9]  = mkv("j",           32'hBFC00100, mk_j(6'h02, 26'h0000040), 1'b0, 32'd0, 32'd0, 1'b1, 32'hB0000100, 1'b1);
        vecs[10] = mkv("jal",         32'h00000000, mk_j(6'h03, 26'h3FFFFFF), 1'b0, 32'd0, 32'd0, 1'b1, 32'h0FFFFFFC, 1'b1);
        vecs[11] = mkv("jr",          32'h00006000, mk_i(6'h00, 5'd4, 5'd0, 16'h0008), 1'b0, 32'h12345678, 32'd0, 1'b1, 32'h12345678, 1'b1);
        vecs[12] = mkv("jalr",        32'h00006000, mk_i(6'h00, 5'd4, 5'd0, 16'hF809), 1'b0, 32'hCAFEBABC, 32'd0, 1'b1, 32'hCAFEBABC, 1'b1);
        vecs[13] = mkv("beq_wrap",    32'hFFFFFFF8, mk_i(6'h04, 5'd1, 5'd2, 16'h0002), 1'b0, 32'd0, 32'd0, 1'b1, 32'h00000004, 1'b1);
        vecs[14] = mkv("addu",        32'h00007000, mk_i(6'h00, 5'd1, 5'd2, 16'h1821), 1'b0, 32'd1, 32'd1, 1'b0, 32'h0, 1'b0);
        vecs[15] = mkv("beq_ferr",    32'h00008000, mk_i(6'h04, 5'd1, 5'd2, 16'h0003), 1'b1, 32'd5, 32'd5, 1'b0, 32'h0, 1'b0);
        vecs[16] = mkv("bltz_zero",   32'h00009000, mk_i(6'h01, 5'd9, 5'd0, 16'h0002), 1'b0, 32'd0, 32'd0, 1'b0, 32'h0, 1'b1);
        vecs[17] = mkv("regimm_rt2",  32'h00009000, mk_i(6'h01, 5'd9, 5'd2, 16'h0002), 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h0, 1'b0);

        resetn       = 1'b0;
        IF_over      = 1'b1;
        IF_ID_bus    = {32'h12345678, 32'h10000001, 1'b1};
        exc_flush    = 1'b1;
        EXE_allow_in = 1'b1;
        rs_value     = 32'd0;
        rt_value     = 32'd0;
        rs_hazard    = 1'b0;

        // Reset wins over a simultaneous flush and latch request.
        tick();
        tick();
        exc_flush = 1'b0;
        #1;
        chk("rst_id_valid",    66'(ID_valid), 66'd0);
        chk("rst_id_over",     66'(ID_over), 66'd0);
        chk("rst_jbr_taken",   66'(jbr_bus[32]), 66'd0);
        chk("rst_allow_in",    66'(ID_allow_in), 66'd1);
        chk("rst_next_fetch1", 66'(next_fetch), 66'd1);
        chk("rst_id_exe_bus",  ID_EXE_bus, 66'd0);
        IF_over = 1'b0;
        #1;
        chk("rst_next_fetch0", 66'(next_fetch), 66'd0);
        resetn = 1'b1;
        tick();

        // Vector table: load, inspect, then depart with a NOP behind it.
        for (int i = 0; i < 18; i++) begin
            flush_idle();
            rs_value = vecs[i].rs;
            rt_value = vecs[i].rt;
            load(vecs[i].pc, vecs[i].inst, vecs[i].fe);
            chk({vecs[i].name, "_valid"}, 66'(ID_valid), 66'd1);
            chk({vecs[i].name, "_taken"}, 66'(jbr_bus[32]), 66'(vecs[i].exp_taken));
            if (vecs[i].exp_taken)
                chk({vecs[i].name, "_target"}, 66'(jbr_bus[31:0]), 66'(vecs[i].exp_target));
            chk({vecs[i].name, "_bus"}, ID_EXE_bus, {vecs[i].pc, vecs[i].inst, vecs[i].fe, 1'b0});
            chk({vecs[i].name, "_rs_addr"}, 66'(rs_addr), 66'(vecs[i].inst[25:21]));
            IF_over      = 1'b1;
            IF_ID_bus    = {vecs[i].pc + 32'd4, 32'h0, 1'b0};
            EXE_allow_in = 1'b1;
            tick();
            IF_over      = 1'b0;
            EXE_allow_in = 1'b0;
            #1;
            chk({vecs[i].name, "_slot"}, 66'(ID_EXE_bus[0]), 66'(vecs[i].exp_jbr));
            chk({vecs[i].name, "_next_inst"}, 66'(ID_EXE_bus[33:2]), 66'd0);
        end

        // Branch in a delay slot re-arms the flag; a plain instruction clears it.
        flush_idle();
        rs_value = 32'd1;
        rt_value = 32'd2;
        load(32'h100, mk_i(6'h04, 5'd1, 5'd2, 16'h0004), 1'b0);
        IF_over      = 1'b1;
        IF_ID_bus    = {32'h104, mk_i(6'h05, 5'd1, 5'd2, 16'h0008), 1'b0};
        EXE_allow_in = 1'b1;
        tick();
        chk("ds_bne_flag", 66'(ID_EXE_bus[0]), 66'd1);
        chk("ds_bne_taken", 66'(jbr_bus[32]), 66'd1);
        IF_ID_bus = {32'h108, 32'h0, 1'b0};
        tick();
        chk("ds_rearm_flag", 66'(ID_EXE_bus[0]), 66'd1);
        IF_ID_bus = {32'h10C, 32'h0, 1'b0};
        tick();
        chk("ds_clear_flag", 66'(ID_EXE_bus[0]), 66'd0);

        // Operand hazard stalls ID and fetch for three cycles.
        flush_idle();
        held = mk_i(6'h04, 5'd3, 5'd4, 16'h0001);
        load(32'h7000, held, 1'b0);
        rs_hazard    = 1'b1;
        IF_over      = 1'b1;
        IF_ID_bus    = {32'h7004, 32'hDEADBEEF, 1'b0};
        EXE_allow_in = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("haz_id_over", 66'(ID_over), 66'd0);
            chk("haz_allow_in", 66'(ID_allow_in), 66'd0);
            chk("haz_next_fetch", 66'(next_fetch), 66'd0);
            tick();
            chk("haz_inst_held", 66'(ID_EXE_bus[33:2]), 66'(held));
        end
        rs_hazard = 1'b0;

        // Flush during a departing jump with fetch ready: flush wins.
        flush_idle();
        load(32'h8000, mk_j(6'h02, 26'h10), 1'b0);
        IF_over      = 1'b1;
        IF_ID_bus    = {32'h8004, 32'h0, 1'b0};
        EXE_allow_in = 1'b1;
        exc_flush    = 1'b1;
        #1;
        chk("fl_allow_in", 66'(ID_allow_in), 66'd1);
        chk("fl_next_fetch", 66'(next_fetch), 66'd1);
        tick();
        exc_flush = 1'b0;
        IF_over   = 1'b0;
        #1;
        chk("fl_id_valid", 66'(ID_valid), 66'd0);
        chk("fl_jbr_taken", 66'(jbr_bus[32]), 66'd0);
        load(32'h9000, 32'h0, 1'b0);
        chk("fl_slot_clear", 66'(ID_EXE_bus[0]), 66'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_front.md
DECODE_FRONT -- requirements
Module: decode_front

Interface
REQ-001 Parameters: START_FLAG_W 1 (delay-slot flag width); ID_EXE_W 66 (downstream bus width).
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  reset: synchronous, active-low.
- IF_over  in  1  fetch stage holds a completed instruction.
- IF_ID_bus  in  65  {pc[31:0], inst[31:0], fetch_error}.
- exc_flush  in  1  exception redirect this cycle; cancels the ID contents.
- EXE_allow_in  in  1  execute stage can accept an instruction.
- rs_value  in  32  register-file value for inst[25:21].
- rs_hazard  in  1  rs or rt operand not yet available.
- rt_value  in  32  register-file value for inst[20:16].
- rs_addr  out  5  inst[25:21] of the latched instruction.
- rt_addr  out  5  inst[20:16] of the latched instruction.
- ID_valid  out  1  ID holds an instruction.
- ID_over  out  1  ID work complete.
- ID_allow_in  out  1  ID can accept from fetch.
- next_fetch  out  1  fetch may advance its PC.
- jbr_bus  out  33  {jbr_taken, jbr_target[31:0]} to fetch.
- ID_EXE_bus  out  66  {pc, inst, fetch_error, is_delay_slot}.

Function
REQ-003 ID_allow_in SHALL equal !ID_valid || (ID_over && EXE_allow_in).
REQ-004 next_fetch SHALL equal exc_flush || (IF_over && ID_allow_in).
REQ-005 On a clock edge with exc_flush=1, ID_valid SHALL become 0, regardless of any other input.
REQ-006 Otherwise, when ID_allow_in=1, ID_valid SHALL take the value of IF_over.
REQ-007 When IF_over && ID_allow_in && !exc_flush, the block SHALL latch pc, inst and fetch_error from IF_ID_bus; otherwise the latched fields SHALL hold.
REQ-008 ID_over SHALL equal ID_valid && !rs_hazard.
REQ-009 The block SHALL decode the branch/jump class as follows:
- BEQ 000100; BNE 000101; BLEZ 000110; BGTZ 000111.
- REGIMM 000001 with rt=00000 for BLTZ and rt=00001 for BGEZ.
- J 000010; JAL 000011.
- SPECIAL funct 001000 for JR and 001001 for JALR.
REQ-010 Branch target SHALL be (pc+4) + {sext(inst[15:0]),2'b00} in 32-bit modulo arithmetic, wrapping with no error.
REQ-011 J/JAL target SHALL be {pc_plus4[31:28], inst[25:0], 2'b00}.
REQ-012 JR/JALR target SHALL be rs_value.
REQ-013 Branch conditions SHALL use rs_value (and rt_value) as signed 32-bit values: equal, not-equal, <=0, >0, <0, >=0.
REQ-014 jbr_taken SHALL equal ID_valid && !fetch_error && (jump || branch condition true); jbr_target SHALL be don't-care when jbr_taken=0.
REQ-015 An instruction with fetch_error=1 SHALL be treated as non-branch and forwarded unchanged, with fetch_error preserved.
REQ-016 The delay-slot flag register slot_pending SHALL be set when a branch/jump-class instruction leaves ID (ID_over && EXE_allow_in), taken or not.
REQ-017 The next instruction leaving ID SHALL carry is_delay_slot=1, and slot_pending SHALL clear on that departure.
REQ-018 exc_flush SHALL clear slot_pending.
REQ-019 A branch/jump in a delay slot SHALL set slot_pending again in the cycle it leaves.
REQ-020 ID_EXE_bus SHALL present the latched fields combinationally; downstream qualifies it with ID_over.

Reset
REQ-021 Under resetn=0 the following SHALL be 0 at the next edge: ID_valid, slot_pending, latched pc, latched inst, latched fetch_error.
REQ-022 Consequently, after reset: ID_over=0, jbr_taken=0, ID_allow_in=1, next_fetch=exc_flush||IF_over.
REQ-023 Reset SHALL override exc_flush and a simultaneous latch.

Structure
REQ-024 The shared package SHALL hold:
- opcode and funct constants;
- the IF_ID (65) and ID_EXE (66) bus widths;
- the jbr_bus width (33).
REQ-025 A combinational sub-module branch_unit SHALL take inst, pc, rs_value and rt_value and produce is_jbr, taken and target; the handshake and delay-slot state stay in decode_front.

Verification
REQ-026 Scenario: BEQ at pc=0xBFC00010, imm=0x0003, rs_value=rt_value=5 -> jbr_bus={1,0xBFC00020}; the next departing instruction has is_delay_slot=1.
REQ-027 Scenario: BNE with imm=0xFFFF and equal operands -> jbr_taken=0; slot_pending still set after departure.
REQ-028 Scenario: J at pc=0xBFC00100 with index 0x0000040 -> target 0xB0000100.
REQ-029 Scenario: rs_hazard=1 holds for 3 cycles with IF_over=1 -> ID_over=0, ID_allow_in=0, next_fetch=0 throughout; latched inst unchanged.
REQ-030 Scenario: exc_flush coincides with IF_over && ID_allow_in -> ID_valid=0 next cycle, next_fetch=1, slot_pending=0.
REQ-031 Scenario: fetch_error=1 with a BEQ encoding -> jbr_taken=0; ID_EXE_bus fetch_error=1.
